// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - frames the UART receiver byte stream into checked payload packets
// Optional checksum byte and CHECK state are built when UART_FRAME_CHECKSUM_EN is defined.
module uart_rx_frame_ctrl #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         TIMEOUT_BITS = 20,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Out_Valid,
    input  logic       i_Out_Ready,
    output logic [7:0] o_Out_Byte,
    output logic       o_Out_Last,
    output logic       o_Err_Pulse,
    output logic [1:0] o_Err_Code
);
    localparam int          IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int          LEN_W     = IDX_W + 1;
    localparam logic [23:0] TO_TERM   = 24'(CLKS_PER_BIT * TIMEOUT_BITS - 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_OVERRUN  = 2'b00;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
`endif
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_LENGTH   = 2'b11;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
`ifdef UART_FRAME_CHECKSUM_EN
        CHECK   = 3'd3,
`endif
        DRAIN   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_m1;
    logic [IDX_W-1:0]   wptr;
    logic [IDX_W-1:0]   rptr;
    logic [23:0]        to_cnt;
    logic [7:0]         buffer [MAX_LEN];
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]         sum;
`endif

    logic               counting;
    logic               to_term;
    logic               len_ok;
    logic               pay_last;
    logic               drain_last;
    logic               err_set;
    logic [1:0]         err_val;

    assign len_m1     = len - LEN_W'(1);
    assign counting   = (state == LEN) || (state == PAYLOAD)
`ifdef UART_FRAME_CHECKSUM_EN
                        || (state == CHECK)
`endif
                        ;
    assign to_term    = counting && (to_cnt == TO_TERM);
    assign len_ok     = (i_RX_Byte != 8'h00) && (i_RX_Byte <= MAX_LEN_B);
    assign pay_last   = ({1'b0, wptr} == len_m1);
    assign drain_last = ({1'b0, rptr} == len_m1);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // An arriving byte always takes priority over a simultaneous timeout.
    always_comb begin
        state_next = state;
        case (state)
            HUNT: begin
                if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                if (i_RX_DV) begin
                    state_next = len_ok ? PAYLOAD : HUNT;
                end else if (to_term) begin
                    state_next = HUNT;
                end
            end
            PAYLOAD: begin
                if (i_RX_DV) begin
                    if (pay_last) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DRAIN;
`endif
                    end
                end else if (to_term) begin
                    state_next = HUNT;
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            CHECK: begin
                if (i_RX_DV) begin
                    state_next = (i_RX_Byte == sum) ? DRAIN : HUNT;
                end else if (to_term) begin
                    state_next = HUNT;
                end
            end
`endif
            DRAIN: begin
                if (i_Out_Ready && drain_last) begin
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        o_Out_Valid = 1'b0;
        o_Out_Byte  = 8'h00;
        o_Out_Last  = 1'b0;
        err_set     = 1'b0;
        err_val     = ERR_OVERRUN;
        case (state)
            LEN: begin
                if (i_RX_DV) begin
                    if (!len_ok) begin
                        err_set = 1'b1;
                        err_val = ERR_LENGTH;
                    end
                end else if (to_term) begin
                    err_set = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
            PAYLOAD: begin
                if (!i_RX_DV && to_term) begin
                    err_set = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            CHECK: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte != sum) begin
                        err_set = 1'b1;
                        err_val = ERR_CHECKSUM;
                    end
                end else if (to_term) begin
                    err_set = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
`endif
            DRAIN: begin
                o_Out_Valid = 1'b1;
                o_Out_Byte  = buffer[rptr];
                o_Out_Last  = drain_last;
                if (i_RX_DV) begin
                    err_set = 1'b1;
                    err_val = ERR_OVERRUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            len         <= '0;
            wptr        <= '0;
            rptr        <= '0;
            to_cnt      <= '0;
            o_Err_Pulse <= 1'b0;
            o_Err_Code  <= ERR_OVERRUN;
`ifdef UART_FRAME_CHECKSUM_EN
            sum         <= 8'h00;
`endif
        end else begin
            o_Err_Pulse <= err_set;
            if (err_set) begin
                o_Err_Code <= err_val;
            end
            // Cleared on terminal count too, so HUNT always sees an idle counter.
            if (!counting || i_RX_DV || to_term) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 24'd1;
            end
            case (state)
                LEN: begin
                    if (i_RX_DV && len_ok) begin
                        len  <= i_RX_Byte[LEN_W-1:0];
                        wptr <= '0;
                        rptr <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        sum  <= i_RX_Byte;
`endif
                    end
                end
                PAYLOAD: begin
                    if (i_RX_DV) begin
                        wptr <= wptr + IDX_W'(1);
`ifdef UART_FRAME_CHECKSUM_EN
                        sum  <= sum + i_RX_Byte;
`endif
                    end
                end
                DRAIN: begin
                    if (i_Out_Ready) begin
                        rptr <= rptr + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if ((state == PAYLOAD) && i_RX_DV) begin
            buffer[wptr] <= i_RX_Byte;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed vector bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef struct {
        int           n_in;
        logic [127:0] in_b;
        int           sync_at;
        int           ck_mode;
        int           n_out;
        logic [127:0] out_b;
        int           n_err;
        logic [1:0]   err_code;
    } vec_t;

    logic       i_Clock     = 1'b0;
    logic       i_Reset     = 1'b1;
    logic       i_RX_DV     = 1'b0;
    logic [7:0] i_RX_Byte   = 8'h00;
    logic       i_Out_Ready = 1'b1;
    logic       o_Out_Valid;
    logic [7:0] o_Out_Byte;
    logic       o_Out_Last;
    logic       o_Err_Pulse;
    logic [1:0] o_Err_Code;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    int         last_strobe  = 0;
    logic [7:0] out_q[$];
    logic       out_last_q[$];
    int         out_cyc_q[$];
    logic [1:0] err_q[$];
    int         err_cyc_q[$];
    logic       stall_prev = 1'b0;
    logic [8:0] held       = 9'h000;
    logic       err_prev   = 1'b0;
    vec_t       vecs [8];
    int         nvec;

    uart_rx_frame_ctrl dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .o_Out_Valid (o_Out_Valid),
        .i_Out_Ready (i_Out_Ready),
        .o_Out_Byte  (o_Out_Byte),
        .o_Out_Last  (o_Out_Last),
        .o_Err_Pulse (o_Err_Pulse),
        .o_Err_Code  (o_Err_Code)
    );

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge i_Clock) begin
        if (i_Reset) begin
            stall_prev = 1'b0;
            err_prev   = 1'b0;
        end else begin
            if (stall_prev) check("stall_hold", {o_Out_Valid, o_Out_Last, o_Out_Byte}, {1'b1, held});
            if (o_Err_Pulse) check("err_pulse_width", 32'(err_prev), 0);
            if (o_Out_Valid && i_Out_Ready) begin
                out_q.push_back(o_Out_Byte);
                out_last_q.push_back(o_Out_Last);
                out_cyc_q.push_back(cyc);
            end
            if (o_Err_Pulse) begin
                err_q.push_back(o_Err_Code);
                err_cyc_q.push_back(cyc);
            end
            stall_prev = o_Out_Valid && !i_Out_Ready;
            held       = {o_Out_Last, o_Out_Byte};
            err_prev   = o_Err_Pulse;
        end
    end

    task automatic clear_q();
        out_q.delete();
        out_last_q.delete();
        out_cyc_q.delete();
        err_q.delete();
        err_cyc_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_Clock); #1;
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(posedge i_Clock); #1;
        i_RX_DV     = 1'b0;
        last_strobe = cyc;
    endtask

    task automatic pulse_reset();
        @(posedge i_Clock); #1;
        i_Reset = 1'b1;
        @(posedge i_Clock); #1;
        i_Reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] b;
        logic [7:0] ck;
        clear_q();
        ck = 8'h00;
        for (int i = 0; i < v.n_in; i++) begin
            b = v.in_b[8*(v.n_in-1-i) +: 8];
            if (i > v.sync_at) ck = ck + b;
            send_byte(b);
        end
        if (CK_EN && v.ck_mode == 1) send_byte(ck);
        if (CK_EN && v.ck_mode == 2) send_byte(ck - 8'd1);
        repeat (40) @(posedge i_Clock);
        #1;
        check($sformatf("v%0d_nout", idx), out_q.size(), v.n_out);
        for (int j = 0; j < v.n_out && j < out_q.size(); j++) begin
            check($sformatf("v%0d_data%0d", idx, j), out_q[j], v.out_b[8*(v.n_out-1-j) +: 8]);
            check($sformatf("v%0d_last%0d", idx, j), out_last_q[j], 32'(j == v.n_out - 1));
            check($sformatf("v%0d_cyc%0d", idx, j), out_cyc_q[j], last_strobe + j);
        end
        check($sformatf("v%0d_nerr", idx), err_q.size(), v.n_err);
        if (v.n_err > 0 && err_q.size() > 0) begin
            check($sformatf("v%0d_code", idx), err_q[0], v.err_code);
            check($sformatf("v%0d_errcyc", idx), err_cyc_q[0], last_strobe);
        end
    endtask

    initial begin
        int s;
        vecs[0] = '{n_in:5, in_b:128'hA5_03_11_22_33, sync_at:0, ck_mode:1,
                    n_out:3, out_b:128'h11_22_33, n_err:0, err_code:2'b00};
        vecs[1] = '{n_in:6, in_b:128'h00_FF_A5_02_AB_CD, sync_at:2, ck_mode:1,
                    n_out:2, out_b:128'hAB_CD, n_err:0, err_code:2'b00};
        vecs[2] = '{n_in:2, in_b:128'hA5_00, sync_at:0, ck_mode:0,
                    n_out:0, out_b:128'h0, n_err:1, err_code:2'b11};
        vecs[3] = '{n_in:2, in_b:128'hA5_11, sync_at:0, ck_mode:0,
                    n_out:0, out_b:128'h0, n_err:1, err_code:2'b11};
        vecs[4] = '{n_in:4, in_b:128'hA5_02_A5_A5, sync_at:0, ck_mode:1,
                    n_out:2, out_b:128'hA5_A5, n_err:0, err_code:2'b00};
        vecs[5] = '{n_in:6, in_b:128'hA5_04_FF_FF_FF_FF, sync_at:0, ck_mode:1,
                    n_out:4, out_b:128'hFF_FF_FF_FF, n_err:0, err_code:2'b00};
        vecs[6] = '{n_in:3, in_b:128'hA5_01_7E, sync_at:0, ck_mode:1,
                    n_out:1, out_b:128'h7E, n_err:0, err_code:2'b00};
        nvec = 7;
`ifdef UART_FRAME_CHECKSUM_EN
        vecs[6] = '{n_in:4, in_b:128'hA5_02_10_20, sync_at:0, ck_mode:2,
                    n_out:0, out_b:128'h0, n_err:1, err_code:2'b01};
        vecs[7] = '{n_in:3, in_b:128'hA5_01_7E, sync_at:0, ck_mode:1,
                    n_out:1, out_b:128'h7E, n_err:0, err_code:2'b00};
        nvec = 8;
`endif

        repeat (4) @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        @(negedge i_Clock);
        check("rst_valid", o_Out_Valid, 0);
        check("rst_byte", o_Out_Byte, 0);
        check("rst_last", o_Out_Last, 0);
        check("rst_pulse", o_Err_Pulse, 0);
        check("rst_code", o_Err_Code, 0);

        for (int k = 0; k < nvec; k++) run_vec(vecs[k], k);

        // Silence after a payload byte: timeout error lands 8680 edges later.
        clear_q();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        s = last_strobe;
        repeat (8700) @(posedge i_Clock);
        #1;
        check("to_nerr", err_q.size(), 1);
        if (err_q.size() > 0) begin
            check("to_code", err_q[0], 2'b10);
            check("to_cyc", err_cyc_q[0], s + 8680);
        end
        check("to_nout", out_q.size(), 0);

        // Byte strobed in the terminal-count cycle must win.
        clear_q();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        repeat (8678) @(posedge i_Clock);
        send_byte(8'h20);
        if (CK_EN) send_byte(8'h32);
        repeat (40) @(posedge i_Clock);
        #1;
        check("tc_nerr", err_q.size(), 0);
        check("tc_nout", out_q.size(), 2);
        if (out_q.size() == 2) begin
            check("tc_d0", out_q[0], 8'h10);
            check("tc_d1", out_q[1], 8'h20);
        end

        // Full 16-byte frame with ready toggling and an RX strobe mid-drain.
        clear_q();
        send_byte(8'hA5); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
        if (CK_EN) send_byte(8'h88);
        for (int k = 0; k < 60; k++) begin
            @(posedge i_Clock); #1;
            i_Out_Ready = k[0];
            i_RX_DV     = (k == 6);
            i_RX_Byte   = 8'h5A;
        end
        i_RX_DV     = 1'b0;
        i_Out_Ready = 1'b1;
        repeat (10) @(posedge i_Clock);
        #1;
        check("bp_nout", out_q.size(), 16);
        for (int j = 0; j < 16 && j < out_q.size(); j++) begin
            check($sformatf("bp_data%0d", j), out_q[j], 8'h30 + 8'(j));
            check($sformatf("bp_last%0d", j), out_last_q[j], 32'(j == 15));
        end
        check("ovr_nerr", err_q.size(), 1);
        if (err_q.size() > 0) check("ovr_code", err_q[0], 2'b00);

        // Error code holds, then reset during a stalled drain clears everything.
        send_byte(8'hA5); send_byte(8'h00);
        repeat (5) @(posedge i_Clock);
        #1;
        check("code_hold", o_Err_Code, 2'b11);
        i_Out_Ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        if (CK_EN) send_byte(8'h09);
        repeat (3) @(posedge i_Clock);
        #1;
        check("stall_valid", o_Out_Valid, 1);
        check("stall_byte", o_Out_Byte, 8'h01);
        pulse_reset();
        check("rd_valid", o_Out_Valid, 0);
        check("rd_byte", o_Out_Byte, 0);
        check("rd_last", o_Out_Last, 0);
        check("rd_pulse", o_Err_Pulse, 0);
        check("rd_code", o_Err_Code, 0);

        // Reset mid-payload, then a fresh frame must come through intact.
        i_Out_Ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        pulse_reset();
        clear_q();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h77); send_byte(8'h88);
        if (CK_EN) send_byte(8'h01);
        repeat (40) @(posedge i_Clock);
        #1;
        check("rp_nout", out_q.size(), 2);
        if (out_q.size() == 2) begin
            check("rp_d0", out_q[0], 8'h77);
            check("rp_d1", out_q[1], 8'h88);
            check("rp_cyc", out_cyc_q[0], last_strobe);
        end
        check("rp_nerr", err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

- Sequences the byte stream from the UART receiver (`RX_DV`/`RX_Byte` strobes) into framed packets.
- Frame format: sync byte, length byte, payload, checksum byte.
- Buffers the payload internally and releases it on a valid/ready stream only after the frame passes length, timeout and checksum checks.
- Sits between the UART receiver and the command decoder; reports framing errors as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 434, clocks per UART bit (50 MHz, 115200 baud); used for the timeout.
- `TIMEOUT_BITS`, 20, inter-byte timeout in bit times.
- `MAX_LEN`, 16, maximum payload length in bytes (1..16).
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `i_Clock`  in  1  system clock; single clock domain.
- `i_Reset`  in  1  reset; synchronous, active-high.
- `i_RX_DV`  in  1  one-cycle byte-valid strobe from the UART receiver.
- `i_RX_Byte`  in  8  received byte; valid when `i_RX_DV`=1.
- `o_Out_Valid`  out  1  payload byte available.
- `i_Out_Ready`  in  1  consumer accepts byte.
- `o_Out_Byte`  out  8  payload byte.
- `o_Out_Last`  out  1  marks the final payload byte of the frame.
- `o_Err_Pulse`  out  1  one-cycle error strobe.
- `o_Err_Code`  out  2  error code: 00 overrun, 01 checksum, 10 timeout, 11 bad length.

## Operation
**States**
- `HUNT`
  - Accepted byte equal to `SYNC_BYTE` → `LEN`.
  - Any other byte is discarded silently.
- `LEN`
  - Byte in 1..`MAX_LEN`: latch length L, set running sum = L, write pointer = 0 → `PAYLOAD`.
  - Otherwise: error 11 → `HUNT`.
- `PAYLOAD`
  - Each byte is written to buffer[wptr], added to the sum, and increments wptr.
  - After byte L → `CHECK`.
  - `SYNC_BYTE` values here are treated as ordinary data.
- `CHECK`
  - Byte == sum[7:0] → `DRAIN`.
  - Otherwise: error 01 → `HUNT`; buffer contents discarded.
- `DRAIN`
  - `o_Out_Valid`=1, `o_Out_Byte`=buffer[rptr].
  - A transfer occurs when `o_Out_Valid` and `i_Out_Ready` are both 1; it increments rptr.
  - `o_Out_Last`=1 when rptr==L-1.
  - Transfer of the last byte → `HUNT`.
  - Any `i_RX_DV` in `DRAIN`: byte dropped, error 00.

**Arithmetic and timeout**
- Checksum is an 8-bit sum with modulo-256 wrap: L plus all payload bytes.
- Timeout counter is 24 bits. It clears on every accepted byte and counts while in `LEN`, `PAYLOAD` or `CHECK`.
- On reaching `CLKS_PER_BIT*TIMEOUT_BITS-1`: error 10 → `HUNT`.
- `CLKS_PER_BIT*TIMEOUT_BITS` must be < 2^24.
- Counter is idle (held at 0) in `HUNT` and `DRAIN`.

**Boundary rules**
- `i_RX_DV` and timeout terminal count in the same cycle: the byte wins; counter clears, no error.
- L=`MAX_LEN`: buffer fills exactly; no wrap.
- L=0 or L>`MAX_LEN`: bad length.
- `o_Err_Code` holds its last value between pulses.

## Timing
- **Reset values:** `o_Out_Valid`=0, `o_Out_Byte`=0, `o_Out_Last`=0, `o_Err_Pulse`=0, `o_Err_Code`=00; state `HUNT`; pointers, sum and counter = 0.
- **Reset mid-operation:** takes effect at the next clock edge from any state; partial or undrained frames are discarded.
- **Drain start:** `o_Out_Valid` rises on the cycle after the `i_RX_DV` cycle of the final frame byte.
- **Drain throughput:** one byte per cycle while `i_Out_Ready`=1. `o_Out_Byte` and `o_Out_Last` are stable while valid and not ready.
- **Next frame:** after the last transfer, `o_Out_Valid` drops on the next cycle; `HUNT` can accept a sync byte that same cycle.
- **Error pulses:** `o_Err_Pulse` is asserted for exactly one cycle, on the cycle after the offending strobe or terminal count.

## Configuration
- Macro `UART_FRAME_CHECKSUM_EN`.
- **Defined:** `CHECK` state present; frame = sync, len, payload, checksum.
- **Undefined:**
  - No checksum byte: after payload byte L the controller goes directly to `DRAIN`.
  - Error code 01 is never produced.
  - Sum logic is removed.

## Test plan
- **Good frame:** A5, 03, 11, 22, 33, 69 with ready=1 → outputs 11, 22, 33 on consecutive cycles; Last on 33; no error.
- **Bad checksum:** A5, 02, 10, 20, 31 → error 01 pulse; `o_Out_Valid` never rises; next good frame accepted.
- **Length rejects:** A5, 00 → error 11; A5, 11 (17 > `MAX_LEN`) → error 11; leading junk 00, FF before A5 ignored.
- **Timeout:** A5, 02, 10, then silence → error 10 exactly 8680 cycles after the byte-10 strobe. A byte arriving on the terminal-count cycle → no error.
- **Backpressure and overrun:**
  - Good frame with L=16, ready toggling 1/0: all 16 bytes in order, outputs stable while stalled.
  - RX strobe during `DRAIN` → error 00, drained data unaffected.
- **Reset:** `i_Reset` pulsed mid-`PAYLOAD` and mid-`DRAIN` → all outputs 0 on the next cycle; a following full frame is delivered correctly.
